mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The parameter list SHALL be: STARVE_LIMIT, 3, the number of consecutive data grants made while a fetch waits before the fetch is forced through (legal range 1..15).
REQ-002 The ports SHALL be, with a single clock domain clk and a synchronous active-high reset rst:
  clk  in  1  clock
  rst  in  1  reset, sampled on clk rising edge
  if_req  in  1  fetch request, held until if_resp_valid or flush
  if_addr  in  64  fetch byte address
  if_resp_valid  out  1  fetch response pulse
  if_resp_instr  out  32  fetched instruction
  d_req  in  1  load/store request, held until d_resp_valid
  d_we  in  1  1 = store
  d_addr  in  64  data byte address
  d_wdata  in  64  store data
  d_wmask  in  8  store byte mask
  d_resp_valid  out  1  data response pulse
  d_resp_rdata  out  64  load data
  flush  in  1  redirect from execute; cancels in-flight fetch
  if_stall  out  1  fetch side must hold
  d_stall  out  1  memory stage must hold
  mem_req_valid  out  1  shared port request valid
  mem_req_ready  in  1  shared port accepts request
  mem_addr  out  64  request address
  mem_we  out  1  request write enable
  mem_wdata  out  64  request write data
  mem_wmask  out  8  request byte mask
  mem_resp_valid  in  1  shared port response/ack
  mem_resp_rdata  in  64  shared port read data

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one transaction outstanding at most.
REQ-004 Arbitration SHALL occur only in IDLE; grant data if d_req and not (if_req and starve_cnt==STARVE_LIMIT and not flush); else grant fetch if if_req and not flush; else stay IDLE.
REQ-005 On grant SHALL latch owner, address, we, wdata, wmask (fetch: we=0, wmask=0, wdata=0) and move to ISSUE next cycle.
REQ-006 In ISSUE mem_req_valid SHALL be 1 with latched payload stable until mem_req_ready; ISSUE->WAIT on the cycle mem_req_ready=1.
REQ-007 In WAIT, mem_resp_valid=1 SHALL capture mem_resp_rdata and move to RESP; mem_resp_valid outside WAIT SHALL be ignored.
REQ-008 RESP SHALL last exactly one cycle then return to IDLE; no arbitration in RESP.
REQ-009 d_resp_valid SHALL be 1 only in RESP with owner=data; d_resp_rdata = captured data (stores included).
REQ-010 if_resp_valid SHALL be 1 only in RESP with owner=fetch, drop=0, flush=0; if_resp_instr = captured[63:32] if latched addr[2]=1 else captured[31:0].
REQ-011 flush while owner=fetch in ISSUE/WAIT/RESP SHALL set drop; the bus transaction still completes unchanged; drop clears on return to IDLE.
REQ-012 flush SHALL never affect a data transaction.
REQ-013 starve_cnt (4-bit) SHALL increment, saturating at STARVE_LIMIT, on each data grant with if_req=1; clear on fetch grant or in IDLE with if_req=0.
REQ-014 if_stall SHALL equal if_req and not if_resp_valid; d_stall SHALL equal d_req and not d_resp_valid (combinational).
REQ-015 Minimum latency SHALL be grant at cycle t, mem_req_valid at t+1, response pulse at t+3 with ready at t+1 and mem_resp_valid at t+2.
REQ-016 Simultaneous d_req and if_req with starve_cnt<STARVE_LIMIT SHALL grant data.

Reset
REQ-017 rst=1 SHALL force IDLE, starve_cnt=0, drop=0, latched payload=0, and all outputs 0 on the following cycle, abandoning any in-flight transaction.
REQ-018 After rst deasserts, the first grant SHALL be possible in the first IDLE cycle.

Verification
REQ-019 Fetch only: if_req=1, if_addr=0x80000004, ready tied 1, resp one cycle after ready with rdata=0x0000001300000093 -> if_resp_valid one cycle pulse, if_resp_instr=0x00000013, if_stall low that cycle.
REQ-020 Contention: d_req and if_req both held, STARVE_LIMIT=3 -> grants D,D,D,I; starve_cnt 1,2,3,0.
REQ-021 Store: d_we=1, d_addr=0x80001000, d_wdata=0xDEADBEEF, d_wmask=0x0F, ready delayed 4 cycles -> mem_* payload stable all 4 cycles, d_resp_valid once after ack.
REQ-022 Flush: fetch in WAIT, flush pulse -> transaction completes on bus, if_resp_valid stays 0, next IDLE grants new if_addr.
REQ-023 Reset mid-WAIT: rst pulse -> next cycle state IDLE, mem_req_valid=0, later mem_resp_valid ignored, no response pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store traffic.
// One transaction in flight; a waiting fetch is forced through after STARVE_LIMIT data grants.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_resp_valid,
  output logic [31:0] if_resp_instr,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic        d_resp_valid,
  output logic [63:0] d_resp_rdata,
  input  logic        flush,
  output logic        if_stall,
  output logic        d_stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [63:0] mem_addr,
  output logic        mem_we,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [63:0] mem_resp_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} ArbState;

  localparam logic [3:0] starveMax = 4'(STARVE_LIMIT);

  ArbState     state;
  logic        ownerData;
  logic        drop;
  logic [3:0]  starveCnt;
  logic [63:0] respData;
  logic        grantData;
  logic        grantFetch;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    grantData  = 1'b0;
    grantFetch = 1'b0;
    if (state == IDLE) begin
      grantData  = d_req && !(if_req && (starveCnt == starveMax) && !flush);
      grantFetch = !grantData && if_req && !flush;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // sees the pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the payload and response-data registers are reset as well, because
      // mem_* and the response data buses must read zero right after reset.
      state         <= IDLE;
      ownerData     <= 1'b0;
      drop          <= 1'b0;
      starveCnt     <= '0;
      respData      <= '0;
      mem_req_valid <= 1'b0;
      mem_addr      <= '0;
      mem_we        <= 1'b0;
      mem_wdata     <= '0;
      mem_wmask     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grantData) begin
            ownerData     <= 1'b1;
            mem_addr      <= d_addr;
            mem_we        <= d_we;
            mem_wdata     <= d_wdata;
            mem_wmask     <= d_wmask;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end else if (grantFetch) begin
            ownerData     <= 1'b0;
            mem_addr      <= if_addr;
            mem_we        <= 1'b0;
            mem_wdata     <= '0;
            mem_wmask     <= '0;
            mem_req_valid <= 1'b1;
            state         <= ISSUE;
          end
          // Counts data grants that overtook a waiting fetch.
          if (grantData && if_req)
            starveCnt <= (starveCnt >= starveMax) ? starveMax : starveCnt + 4'd1;
          else if (grantFetch || !if_req)
            starveCnt <= '0;
        end
        ISSUE: begin
          if (flush && !ownerData) drop <= 1'b1;
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= WAIT;
          end
        end
        WAIT: begin
          if (flush && !ownerData) drop <= 1'b1;
          if (mem_resp_valid) begin
            respData <= mem_resp_rdata;
            state    <= RESP;
          end
        end
        RESP: begin
          drop  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // A flush in the response cycle itself must also suppress the fetch pulse.
  assign if_resp_valid = (state == RESP) && !ownerData && !drop && !flush;
  assign d_resp_valid  = (state == RESP) && ownerData;
  assign if_resp_instr = mem_addr[2] ? respData[63:32] : respData[31:0];
  assign d_resp_rdata  = respData;
  assign if_stall      = if_req && !if_resp_valid;
  assign d_stall       = d_req && !d_resp_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of the shared-port arbiter.
module tb_mem_arbiter;

  localparam int LIMIT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, flush;
  logic [63:0] if_addr, d_addr, d_wdata;
  logic [7:0]  d_wmask;
  logic        if_resp_valid, d_resp_valid, if_stall, d_stall;
  logic [31:0] if_resp_instr;
  logic [63:0] d_resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_resp_rdata;
  logic [7:0]  mem_wmask;

  int nCompared   = 0;
  int nMismatched = 0;

  // Transaction-level model state
  bit          txnOpen, accepted, respDue, ownerData, dropped, idleNow;
  logic [63:0] expAddr, expWdata, expRdata;
  logic        expWe;
  logic [7:0]  expWmask;
  int          waitCount, grantCount;
  // Memory agent and requester drivers
  bit          agentArmed, realResp, ifDone, dDone;
  int          agentDelay;
  logic [63:0] respData;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_resp_valid(if_resp_valid), .if_resp_instr(if_resp_instr),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata),
    .flush(flush), .if_stall(if_stall), .d_stall(d_stall),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clearInputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; d_wmask = '0;
    flush = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
  endtask

  // Leaves the bench just after the edge that starts the first IDLE cycle with rst low.
  task automatic resetDut();
    rst = 1'b1;
    clearInputs();
    tick();
    tick();
    settle();
    check("rst mem_req_valid", mem_req_valid, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_we/wmask", {mem_we, mem_wmask}, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst if_resp_valid", if_resp_valid, 0);
    check("rst if_resp_instr", if_resp_instr, 0);
    check("rst d_resp_valid", d_resp_valid, 0);
    check("rst d_resp_rdata", d_resp_rdata, 0);
    check("rst stalls", {if_stall, d_stall}, 0);
    tick();
    rst = 1'b0;
  endtask

  // ---------------- randomized phase ----------------
  task automatic driveRandom();
    if (ifDone || !if_req) begin
      ifDone = 0;
      if_req = 1'($urandom_range(0, 1));
      if_addr = 64'h8000_0000 | (64'($urandom_range(0, 255)) << 2);
    end
    if (dDone || !d_req) begin
      dDone = 0;
      d_req = ($urandom_range(0, 2) != 0);
      d_we = 1'($urandom_range(0, 1));
      d_addr = 64'h1000_0000 | (64'($urandom_range(0, 255)) << 3);
      d_wdata = {$urandom, $urandom};
      d_wmask = 8'($urandom);
    end
    flush = txnOpen && !ownerData && ($urandom_range(0, 5) == 0);
    mem_req_ready = ($urandom_range(0, 2) != 0);
    realResp = 0;
    mem_resp_rdata = {$urandom, $urandom};
    if (agentArmed) begin
      if (agentDelay == 0) begin
        respData = {$urandom, $urandom};
        mem_resp_rdata = respData;
        mem_resp_valid = 1;
        realResp = 1;
        agentArmed = 0;
      end else begin
        agentDelay--;
        mem_resp_valid = 0;
      end
    end else begin
      // Stray acknowledges while nothing is awaiting a response must be ignored.
      mem_resp_valid = ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic evalCycle();
    bit expD, expI, expValid, wasResp;
    expD = respDue && ownerData;
    expI = respDue && !ownerData && !dropped && !flush;
    check("rnd d_resp_valid", d_resp_valid, expD);
    check("rnd if_resp_valid", if_resp_valid, expI);
    if (expD) check("rnd d_resp_rdata", d_resp_rdata, expRdata);
    if (expI) check("rnd if_resp_instr", if_resp_instr, expAddr[2] ? expRdata[63:32] : expRdata[31:0]);
    check("rnd if_stall", if_stall, if_req && !expI);
    check("rnd d_stall", d_stall, d_req && !expD);
    expValid = txnOpen && !accepted;
    check("rnd mem_req_valid", mem_req_valid, expValid);
    if (expValid) begin
      check("rnd mem_addr", mem_addr, expAddr);
      check("rnd mem_wdata", mem_wdata, expWdata);
      check("rnd mem_we/wmask", {mem_we, mem_wmask}, {expWe, expWmask});
    end

    if (txnOpen && !ownerData && flush) dropped = 1;
    if (expI || flush) ifDone = 1;
    if (expD) dDone = 1;
    if (expValid && mem_req_ready) begin
      accepted = 1;
      agentArmed = 1;
      agentDelay = $urandom_range(0, 3);
    end
    wasResp = respDue;
    respDue = realResp;
    if (realResp) expRdata = respData;
    if (wasResp) txnOpen = 0;

    if (idleNow) begin
      if (!if_req) waitCount = 0;
      if (d_req && !(if_req && waitCount == LIMIT && !flush)) begin
        ownerData = 1; expAddr = d_addr; expWe = d_we; expWdata = d_wdata; expWmask = d_wmask;
        if (if_req) waitCount = (waitCount >= LIMIT) ? LIMIT : waitCount + 1;
        txnOpen = 1;
      end else if (if_req && !flush) begin
        ownerData = 0; expAddr = if_addr; expWe = 0; expWdata = '0; expWmask = '0;
        waitCount = 0;
        txnOpen = 1;
      end
      if (txnOpen) begin
        accepted = 0; dropped = 0; idleNow = 0; grantCount++;
      end
    end
    if (wasResp) idleNow = 1;
  endtask

  bit expIsData [8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  initial begin
    bit prevValid;
    int gi;

    // Fetch only: upper instruction selected by addr[2]
    resetDut();
    if_req = 1; if_addr = 64'h8000_0004; mem_req_ready = 1;
    settle(); check("fetch idle valid", mem_req_valid, 0); check("fetch idle stall", if_stall, 1);
    tick(); settle();
    check("fetch issue valid", mem_req_valid, 1); check("fetch issue addr", mem_addr, 64'h8000_0004);
    check("fetch issue we/wmask", {mem_we, mem_wmask}, 0); check("fetch issue wdata", mem_wdata, 0);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'h0000_0013_0000_0093;
    settle(); check("fetch wait valid", mem_req_valid, 0); check("fetch wait resp", if_resp_valid, 0);
    tick(); mem_resp_valid = 0;
    settle(); check("fetch resp valid", if_resp_valid, 1); check("fetch resp instr", if_resp_instr, 32'h0000_0013);
    check("fetch resp stall", if_stall, 0); check("fetch resp d_valid", d_resp_valid, 0);
    tick(); if_req = 0;
    settle(); check("fetch after pulse", if_resp_valid, 0);

    // Store held off by a slow ready; requester inputs change after the grant
    resetDut();
    d_req = 1; d_we = 1; d_addr = 64'h8000_1000; d_wdata = 64'hDEAD_BEEF; d_wmask = 8'h0F;
    settle(); check("store idle valid", mem_req_valid, 0);
    for (int c = 1; c <= 5; c++) begin
      tick();
      d_we = 0; d_addr = 64'h5555; d_wdata = '0; d_wmask = 8'hF0;
      flush = (c == 3);
      mem_req_ready = (c == 5);
      settle();
      check($sformatf("store c%0d valid", c), mem_req_valid, 1);
      check($sformatf("store c%0d addr", c), mem_addr, 64'h8000_1000);
      check($sformatf("store c%0d wdata", c), mem_wdata, 64'hDEAD_BEEF);
      check($sformatf("store c%0d we/wmask", c), {mem_we, mem_wmask}, {1'b1, 8'h0F});
    end
    tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h1111_2222_3333_4444;
    settle(); check("store wait d_valid", d_resp_valid, 0); check("store wait stall", d_stall, 1);
    tick(); mem_resp_valid = 0;
    settle(); check("store resp valid", d_resp_valid, 1); check("store resp rdata", d_resp_rdata, 64'h1111_2222_3333_4444);
    check("store resp stall", d_stall, 0);
    tick(); d_req = 0;
    settle(); check("store single pulse", d_resp_valid, 0);

    // Flush while a fetch waits: bus completes, pulse suppressed, new address granted next
    resetDut();
    if_req = 1; if_addr = 64'h8000_0010; mem_req_ready = 1;
    tick();
    tick(); flush = 1; if_addr = 64'h8000_0200;
    tick(); flush = 0; mem_resp_valid = 1; mem_resp_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    settle(); check("flush bus addr", mem_addr, 64'h8000_0010);
    tick(); mem_resp_valid = 0;
    settle(); check("flush resp dropped", if_resp_valid, 0); check("flush stall", if_stall, 1);
    tick(); settle(); check("flush idle valid", mem_req_valid, 0);
    tick(); settle(); check("flush regrant valid", mem_req_valid, 1); check("flush regrant addr", mem_addr, 64'h8000_0200);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'h1234_5678_9ABC_DEF0;
    tick(); mem_resp_valid = 0;
    settle(); check("flush new resp", if_resp_valid, 1); check("flush new instr", if_resp_instr, 32'h9ABC_DEF0);
    tick(); if_req = 0;

    // Reset while waiting for a response abandons the transaction
    resetDut();
    if_req = 1; if_addr = 64'h8000_0020; mem_req_ready = 1;
    tick();
    tick(); rst = 1; if_req = 0; mem_req_ready = 0;
    tick(); rst = 0;
    settle(); check("rstwait valid", mem_req_valid, 0); check("rstwait addr", mem_addr, 0);
    tick(); mem_resp_valid = 1; mem_resp_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick(); mem_resp_valid = 0;
    settle(); check("rstwait pulses", {if_resp_valid, d_resp_valid}, 0);
    check("rstwait rdata", d_resp_rdata, 0); check("rstwait instr", if_resp_instr, 0);
    tick(); settle(); check("rstwait stays idle", mem_req_valid, 0);

    // Contention: both sides held, fast memory -> D,D,D,I repeating
    resetDut();
    if_req = 1; if_addr = 64'h8000_0040; d_req = 1; d_addr = 64'h1000_0080;
    mem_req_ready = 1; mem_resp_valid = 1; mem_resp_rdata = 64'h0123_4567_89AB_CDEF;
    prevValid = 0; gi = 0;
    for (int c = 0; c < 36; c++) begin
      settle();
      if (mem_req_valid && !prevValid) begin
        if (gi < 8) check($sformatf("contention grant %0d", gi), (mem_addr == 64'h1000_0080), expIsData[gi]);
        gi++;
      end
      prevValid = mem_req_valid;
      tick();
    end
    check("contention grant count", (gi >= 8), 1);

    // Randomized traffic against the model
    resetDut();
    txnOpen = 0; accepted = 0; respDue = 0; ownerData = 0; dropped = 0; idleNow = 1;
    waitCount = 0; grantCount = 0; agentArmed = 0; realResp = 0; ifDone = 1; dDone = 1;
    for (int c = 0; c < 3000; c++) begin
      driveRandom();
      settle();
      evalCycle();
      tick();
    end
    check("rnd grants made", (grantCount > 100), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
